// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
//   arb_state_t    : arbiter FSM state (IDLE, OWN)
//   N_REQ_MAX      : widest requester vector the bus mux supports
//   SEL_W_MAX      : widest mux select
//   onehot_to_idx  : index of the set bit of a one-hot vector (0 for all-zero)
package bus_arb_pkg;

    localparam int N_REQ_MAX = 16;
    localparam int SEL_W_MAX = 4;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    function automatic logic [SEL_W_MAX-1:0] onehot_to_idx(input logic [N_REQ_MAX-1:0] v);
        logic [SEL_W_MAX-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ_MAX; i++) begin
            if (v[i]) idx = idx | SEL_W_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
//   req    : request vector
//   last   : index of the previous owner (lowest priority this round)
//   any    : at least one request is present
//   winner : first set request scanning last+1, last+2, ... modulo N_REQ
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = 16,
    parameter int SEL_W = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [SEL_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] low;
    logic [SEL_W-1:0] pos;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Rotate so that requester last+1 lands at bit 0, take the lowest set
        // bit, then rotate the resulting index back into requester numbering.
        start = (32'(last) == N_REQ - 1) ? '0 : last + 1'b1;
        rot   = N_REQ'({req, req} >> start);
        low   = rot & (~rot + 1'b1);
        pos   = SEL_W'(onehot_to_idx(N_REQ_MAX'(low)));
        sum   = {1'b0, pos} + {1'b0, start};
        if (32'(sum) >= N_REQ) sum = sum - (SEL_W + 1)'(N_REQ);
        winner = sum[SEL_W-1:0];
        any    = |req;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter/sequencer for the shared 8-bit, 16-source bus mux.
// Grants one requester at a time with a quantum-bounded tenure; every
// release or forced rotation costs exactly one idle cycle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : level requests, held for the whole tenure
//   lock      : owner keeps the bus past quantum expiry (BUS_ARB_LOCK_EN only)
//   gnt       : registered one-hot grant, zero when no owner
//   sel       : registered mux select = owner index
//   bus_valid : high while a grant is active
//   handover  : one-cycle pulse on the first cycle of each new tenure
// Optional feature macro: BUS_ARB_LOCK_EN (adds the lock input).
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int N_REQ   = 16,
    parameter int SEL_W   = 4,
    parameter int QUANTUM = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef BUS_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             bus_valid,
    output logic             handover
);

    localparam logic [7:0] QMAX = 8'(QUANTUM);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] last, last_n;
    logic [7:0]       cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [SEL_W-1:0] sel_n;
    logic             valid_n;
    logic             hand_n;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             other_req;
    logic             hold;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .last   (last),
        .any    (pick_any),
        .winner (pick_idx)
    );

`ifdef BUS_ARB_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    assign owner_req = |(req & gnt);
    assign other_req = |(req & ~gnt);

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        valid_n = bus_valid;
        hand_n  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = OWN;
                    gnt_n   = N_REQ'(1) << pick_idx;
                    sel_n   = pick_idx;
                    valid_n = 1'b1;
                    hand_n  = 1'b1;
                    cnt_n   = 8'd1;
                    last_n  = pick_idx;
                end else begin
                    gnt_n   = '0;
                    valid_n = 1'b0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == QMAX && !hold) begin
                    if (other_req) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        valid_n = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = 8'd1;
                    end
                end else if (cnt != QMAX) begin
                    cnt_n = cnt + 8'd1;
                end
                // cnt == QMAX with hold: counter saturates, owner keeps the bus
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= SEL_W'(N_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            sel       <= '0;
            bus_valid <= 1'b0;
            handover  <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            bus_valid <= valid_n;
            handover  <= hand_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr (N_REQ=16, QUANTUM=8).
// Stimulus pushes the expected tenure sequence (owner, OWN-cycle length,
// idle gap before it); the monitor pops one entry per handover pulse and
// checks grant, select, tenure length and gap.
module tb_bus_arbiter_rr;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
`ifdef BUS_ARB_LOCK_EN
    logic        lock;
`endif
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        bus_valid;
    logic        handover;

    bus_arbiter_rr #(
        .N_REQ   (16),
        .SEL_W   (4),
        .QUANTUM (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef BUS_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .handover  (handover)
    );

    typedef struct {
        int idx;
        int len;  // expected OWN cycles, 0 = not checked
        int gap;  // expected idle cycles before handover, -1 = not checked
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int len, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    function automatic int oh(input int i);
        return 1 << i;
    endfunction

    // Monitor
    exp_t cur;
    bit   active   = 1'b0;
    int   cur_len  = 0;
    int   idle_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 1'b0;
            idle_cnt = 0;
        end else begin
            if (handover) begin
                if (q.size() == 0) begin
                    chk("unexpected_handover", int'(handover), 0);
                end else begin
                    cur = q.pop_front();
                    if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
                    active  = 1'b1;
                    cur_len = 0;
                end
            end
            if (bus_valid) begin
                if (active) begin
                    cur_len++;
                    chk("gnt_owner", int'(gnt), oh(cur.idx));
                    chk("sel_owner", int'(sel), cur.idx);
                end else begin
                    chk("valid_without_handover", int'(bus_valid), 0);
                end
                idle_cnt = 0;
            end else begin
                chk("gnt_idle_zero", int'(gnt), 0);
                if (active) begin
                    if (cur.len > 0) chk("tenure_len", cur_len, cur.len);
                    active = 1'b0;
                end
                idle_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hv;
        int bad;
        int k;

        rst_n = 1'b0;
        req   = 16'hFFFF;
`ifdef BUS_ARB_LOCK_EN
        lock  = 1'b0;
`endif

        // Reset held with all requests: nothing granted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_gnt", int'(gnt), 0);
            chk("reset_sel", int'(sel), 0);
            chk("reset_valid", int'(bus_valid), 0);
        end
        chk("reset_handover", int'(handover), 0);

        // Full rotation 0..15,0 after release
        push(0, 8, -1);
        for (int i = 1; i < 16; i++) push(i, 8, 1);
        push(0, 0, 1);
        rst_n = 1'b1;
        k = 0;
        while (!bus_valid && k < 3) begin
            tick();
            k++;
        end
        chk("first_gnt", int'(gnt), 16'h0001);
        chk("first_handover", int'(handover), 1);
        tick();
        chk("handover_one_cycle", int'(handover), 0);
        drain("rotation_drain", 200);
        req = 16'h0000;
        tick();
        tick();

        // Single requester: continuous ownership across quantum boundaries
        push(8, 0, -1);
        req = 16'h0100;
        hv  = 0;
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            hv += int'(handover);
            if (!(bus_valid && sel == 4'd8)) bad++;
        end
        chk("single_handover_count", hv, 1);
        chk("single_gaps", bad, 0);
        req = 16'h0000;
        tick();
        tick();

        // Put pointer at 14, then wrap priority with req 15 and 0
        push(14, 0, -1);
        req = 16'h4000;
        tick();
        tick();
        req = 16'h0000;
        tick();
        tick();
        push(15, 8, -1);
        push(0, 0, 1);
        req = 16'h8001;
        drain("wrap_drain", 40);
        req = 16'h0000;
        tick();
        tick();

        // Early release by owner 3 with requester 5 waiting
        push(3, 2, -1);
        push(5, 0, 1);
        req = 16'h0008;
        tick();
        tick();
        req = 16'h0020;
        drain("early_release_drain", 10);
        req = 16'h0000;
        tick();
        tick();

        // Async reset mid-tenure
        push(4, 0, -1);
        req = 16'h0010;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_gnt", int'(gnt), 0);
        chk("async_reset_valid", int'(bus_valid), 0);
        chk("async_reset_sel", int'(sel), 0);
        req = 16'h0006;
        tick();

        // Pointer restored to 15: requester 1 wins first
`ifdef BUS_ARB_LOCK_EN
        lock = 1'b1;
        push(1, 12, -1);
        push(2, 8, 1);
        push(1, 0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        lock = 1'b0;
`else
        push(1, 8, -1);
        push(2, 8, 1);
        push(1, 0, 1);
        rst_n = 1'b1;
`endif
        drain("post_reset_drain", 60);
        req = 16'h0000;
        tick();
        tick();
        tick();
        chk("final_idle_valid", int'(bus_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
